// File: rtl/alien_pkg.sv
// alien_pkg: state encoding and board geometry shared by the alien motion controller.
`default_nettype none

package alien_pkg;

    typedef enum logic [0:0] {
        MOVE = 1'b0,
        DEAD = 1'b1
    } state_t;

    localparam int              POS_W   = 3;
    localparam logic [POS_W-1:0] POS_MAX = 3'd7;

endpackage

`default_nettype wire

// File: rtl/alien_step_timer.sv
// alien_step_timer: enable-gated prescaler with a halvable step period.
// Revision 1.0
`default_nettype none

module alien_step_timer #(
    parameter int TICK_DIV = 25000000,
    parameter int MIN_DIV  = 3125000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    input  logic reload,
    input  logic speed_up,
    output logic tick
);

    localparam int            PW          = $clog2(TICK_DIV) + 1;
    localparam logic [PW-1:0] BASE_PERIOD = PW'(TICK_DIV);
    localparam logic [PW-1:0] MIN_PERIOD  = PW'(MIN_DIV);

    logic [PW-1:0] period;
    logic [PW-1:0] period_next;
    logic [PW-1:0] count;
    logic [PW-1:0] count_next;
    logic [PW-1:0] halved;

    always_comb begin
        tick   = enable && (count == period - PW'(1));
        halved = period >> 1;

        period_next = period;
        if (reload) begin
            period_next = BASE_PERIOD;
        end else if (speed_up) begin
            period_next = (halved < MIN_PERIOD) ? MIN_PERIOD : halved;
        end

        count_next = count;
        if (clear || tick) begin
            count_next = '0;
        end else if (enable) begin
            count_next = count + PW'(1);
        end
        // A shortened period must never leave the count past its new terminal value.
        if (count_next >= period_next) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period <= BASE_PERIOD;
            count  <= '0;
        end else begin
            period <= period_next;
            count  <= count_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alien_motion_ctrl.sv
// alien_motion_ctrl: bouncing alien column tracker with hit/respawn and speed-up.
// Revision 1.0
`default_nettype none

module alien_motion_ctrl
    import alien_pkg::*;
#(
    parameter int TICK_DIV      = 25000000,
    parameter int MIN_DIV       = 3125000,
    parameter int RESPAWN_STEPS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             hit,
    input  logic             speed_up,
    output logic [POS_W-1:0] x_pos,
    output logic             dir,
    output logic             alive,
    output logic             step_pulse
);

    localparam int            RW        = (RESPAWN_STEPS < 1) ? 1 : $clog2(RESPAWN_STEPS + 1);
    localparam logic [RW-1:0] RESP_LOAD = RW'(RESPAWN_STEPS);

    state_t           state;
    state_t           state_next;
    logic [POS_W-1:0] x_next;
    logic             dir_next;
    logic             alive_next;
    logic             step_next;
    logic [RW-1:0]    resp_cnt;
    logic [RW-1:0]    resp_next;
    logic             tick;
    logic             timer_clear;
    logic             timer_reload;

    alien_step_timer #(
        .TICK_DIV (TICK_DIV),
        .MIN_DIV  (MIN_DIV)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .clear    (timer_clear),
        .reload   (timer_reload),
        .speed_up (speed_up),
        .tick     (tick)
    );

    always_comb begin
        state_next   = state;
        x_next       = x_pos;
        dir_next     = dir;
        alive_next   = alive;
        step_next    = 1'b0;
        resp_next    = resp_cnt;
        timer_clear  = 1'b0;
        timer_reload = 1'b0;

        case (state)
            MOVE: begin
                // A hit pre-empts any step falling in the same cycle.
                if (hit) begin
                    state_next  = DEAD;
                    alive_next  = 1'b0;
                    timer_clear = 1'b1;
                    resp_next   = RESP_LOAD;
                end else if (tick) begin
                    step_next = 1'b1;
                    if (dir) begin
                        if (x_pos == POS_MAX) begin
                            x_next   = POS_MAX - POS_W'(1);
                            dir_next = 1'b0;
                        end else begin
                            x_next = x_pos + POS_W'(1);
                        end
                    end else begin
                        if (x_pos == '0) begin
                            x_next   = POS_W'(1);
                            dir_next = 1'b1;
                        end else begin
                            x_next = x_pos - POS_W'(1);
                        end
                    end
                end
            end
            DEAD: begin
                if (tick) begin
                    if (resp_cnt <= RW'(1)) begin
                        state_next   = MOVE;
                        x_next       = '0;
                        dir_next     = 1'b1;
                        alive_next   = 1'b1;
                        step_next    = 1'b1;
                        resp_next    = '0;
                        timer_reload = 1'b1;
                    end else begin
                        resp_next = resp_cnt - RW'(1);
                    end
                end
            end
            default: state_next = MOVE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= MOVE;
            x_pos      <= '0;
            dir        <= 1'b1;
            alive      <= 1'b1;
            step_pulse <= 1'b0;
            resp_cnt   <= '0;
        end else begin
            state      <= state_next;
            x_pos      <= x_next;
            dir        <= dir_next;
            alive      <= alive_next;
            step_pulse <= step_next;
            resp_cnt   <= resp_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alien_motion_ctrl.sv
// tb_alien_motion_ctrl: directed scoreboard bench for alien_motion_ctrl (TICK_DIV=4, MIN_DIV=1, RESPAWN_STEPS=2).
`default_nettype none

module tb_alien_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       hit;
    logic       speed_up;
    logic [2:0] x_pos;
    logic       dir;
    logic       alive;
    logic       step_pulse;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;
    int t      = 0;
    int npulse = 0;

    typedef struct {
        int         cyc;
        logic [2:0] x;
        logic       d;
        logic       a;
    } exp_t;

    exp_t q[$];
    exp_t e;

    alien_motion_ctrl #(
        .TICK_DIV      (4),
        .MIN_DIV       (1),
        .RESPAWN_STEPS (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .hit        (hit),
        .speed_up   (speed_up),
        .x_pos      (x_pos),
        .dir        (dir),
        .alive      (alive),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv)
        else begin
            errors = errors + 1;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push(input int k, input logic [2:0] x, input logic d, input logic a);
        exp_t n;
        n.cyc = base + k;
        n.x   = x;
        n.d   = d;
        n.a   = a;
        q.push_back(n);
    endtask

    task automatic goto(input int k);
        repeat (k - t) @(posedge clk);
        #1;
        t = k;
    endtask

    // Every step pulse must match the next scheduled expectation, including its cycle.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && step_pulse === 1'b1) begin
            npulse = npulse + 1;
            chk("pulse_expected", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("step_cyc", cyc, e.cyc);
                chk("step_x", {29'd0, x_pos}, {29'd0, e.x});
                chk("step_dir", {31'd0, dir}, {31'd0, e.d});
                chk("step_alive", {31'd0, alive}, {31'd0, e.a});
            end
        end
    end

    initial begin
        reset_n  = 1'b0;
        enable   = 1'b0;
        hit      = 1'b0;
        speed_up = 1'b0;
        #12;
        chk("rst_x", {29'd0, x_pos}, 32'd0);
        chk("rst_dir", {31'd0, dir}, 32'd1);
        chk("rst_alive", {31'd0, alive}, 32'd1);
        chk("rst_pulse", {31'd0, step_pulse}, 32'd0);

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        enable  = 1'b1;
        base    = cyc;
        t       = 0;

        // Sweep right, bounce at 7.
        for (int i = 1; i <= 7; i++) push(4 * i, 3'(i), 1'b1, 1'b1);
        push(32, 3'd6, 1'b0, 1'b1);
        goto(33);
        chk("sweep_pulses", npulse, 32'd8);
        chk("sweep_dir", {31'd0, dir}, 32'd0);
        chk("sweep_drain", q.size(), 32'd0);

        // Sweep left to 0, bounce back up to 5.
        for (int i = 0; i < 6; i++) push(36 + 4 * i, 3'(5 - i), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) push(60 + 4 * i, 3'(1 + i), 1'b1, 1'b1);
        goto(61);
        chk("left_bounce_x", {29'd0, x_pos}, 32'd1);
        chk("left_bounce_dir", {31'd0, dir}, 32'd1);

        // Hit coincident with the step at cycle 80.
        goto(79);
        hit = 1'b1;
        goto(80);
        hit = 1'b0;
        chk("hit_x", {29'd0, x_pos}, 32'd5);
        chk("hit_alive", {31'd0, alive}, 32'd0);
        chk("hit_pulse", {31'd0, step_pulse}, 32'd0);
        push(88, 3'd0, 1'b1, 1'b1);
        goto(83);
        hit = 1'b1;
        goto(84);
        hit = 1'b0;
        chk("dead_hit_alive", {31'd0, alive}, 32'd0);
        goto(87);
        chk("dead_still", {31'd0, alive}, 32'd0);
        goto(88);
        chk("respawn_alive", {31'd0, alive}, 32'd1);
        chk("respawn_x", {29'd0, x_pos}, 32'd0);

        // Speed-ups: interval 2, then 1, then floored at 1.
        speed_up = 1'b1;
        goto(89);
        speed_up = 1'b0;
        push(90, 3'd1, 1'b1, 1'b1);
        push(92, 3'd2, 1'b1, 1'b1);
        push(94, 3'd3, 1'b1, 1'b1);
        push(95, 3'd4, 1'b1, 1'b1);
        push(96, 3'd5, 1'b1, 1'b1);
        push(97, 3'd6, 1'b1, 1'b1);
        push(98, 3'd7, 1'b1, 1'b1);
        push(99, 3'd6, 1'b0, 1'b1);
        push(100, 3'd5, 1'b0, 1'b1);
        goto(92);
        speed_up = 1'b1;
        goto(93);
        speed_up = 1'b0;
        goto(96);
        speed_up = 1'b1;
        goto(97);
        speed_up = 1'b0;
        goto(100);
        hit = 1'b1;
        goto(101);
        hit = 1'b0;
        chk("fast_hit_x", {29'd0, x_pos}, 32'd5);
        chk("fast_hit_alive", {31'd0, alive}, 32'd0);
        push(103, 3'd0, 1'b1, 1'b1);
        push(107, 3'd1, 1'b1, 1'b1);
        push(111, 3'd2, 1'b1, 1'b1);
        goto(113);
        chk("speed_drain", q.size(), 32'd0);

        // Freeze for 10 cycles with the prescaler at 2.
        enable = 1'b0;
        goto(123);
        chk("freeze_x", {29'd0, x_pos}, 32'd2);
        chk("freeze_pulse", {31'd0, step_pulse}, 32'd0);
        enable = 1'b1;
        push(125, 3'd3, 1'b1, 1'b1);
        goto(124);
        chk("thaw_early_x", {29'd0, x_pos}, 32'd2);
        goto(125);
        chk("thaw_x", {29'd0, x_pos}, 32'd3);

        // Asynchronous reset while dead.
        hit = 1'b1;
        goto(126);
        hit = 1'b0;
        chk("dead2_alive", {31'd0, alive}, 32'd0);
        goto(128);
        chk("pre_reset_drain", q.size(), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_x", {29'd0, x_pos}, 32'd0);
        chk("areset_dir", {31'd0, dir}, 32'd1);
        chk("areset_alive", {31'd0, alive}, 32'd1);
        chk("areset_pulse", {31'd0, step_pulse}, 32'd0);

        @(posedge clk);
        #1;
        reset_n = 1'b1;
        base    = cyc;
        t       = 0;
        push(4, 3'd1, 1'b1, 1'b1);
        goto(3);
        chk("post_reset_early_x", {29'd0, x_pos}, 32'd0);
        goto(5);
        chk("post_reset_x", {29'd0, x_pos}, 32'd1);
        chk("final_drain", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alien_motion_ctrl.md
ALIEN_MOTION_CTRL -- requirements
Module: alien_motion_ctrl

Interface
REQ-001 SHALL provide parameter TICK_DIV, default 25000000, clk cycles per position step at base speed.
REQ-002 SHALL provide parameter MIN_DIV, default 3125000, floor on the step period after speed-ups.
REQ-003 SHALL provide parameter RESPAWN_STEPS, default 4, step periods spent dead before respawn.
REQ-004 SHALL provide port clk  input  1  system clock; all state updates on the rising edge.
REQ-005 SHALL provide port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL provide port enable  input  1  level; high = game running, low = motion frozen.
REQ-007 SHALL provide port hit  input  1  single-cycle pulse; alien destroyed.
REQ-008 SHALL provide port speed_up  input  1  single-cycle pulse; halve the step period.
REQ-009 SHALL provide port x_pos  output  3  registered alien column 0..7; feeds the 3-bit position input port directly.
REQ-010 SHALL provide port dir  output  1  registered; 1 = moving right (increasing x), 0 = left.
REQ-011 SHALL provide port alive  output  1  registered; 1 in MOVE, 0 in DEAD.
REQ-012 SHALL provide port step_pulse  output  1  registered one-cycle pulse, high exactly in the cycle x_pos takes a new value.

Function
REQ-013 SHALL hold a period register, width ceil(log2(TICK_DIV))+1, initialised to TICK_DIV.
REQ-014 SHALL run a prescaler counting 0..period-1 only while enable=1; tick SHALL fire in the cycle count==period-1, with count returning to 0.
REQ-015 SHALL implement two states, MOVE and DEAD.
REQ-016 MOVE, tick, dir=1: x<7 -> x+1; x==7 -> x becomes 6, dir becomes 0 (bounce, no dwell).
REQ-017 MOVE, tick, dir=0: x>0 -> x-1; x==0 -> x becomes 1, dir becomes 1.
REQ-018 MOVE, hit=1: next state DEAD, alive 0, x_pos and dir held, prescaler cleared, respawn counter loaded with RESPAWN_STEPS; hit SHALL win over a same-cycle tick (no x update).
REQ-019 DEAD, tick: decrement respawn counter; on the tick that brings it to 0, next state MOVE with x_pos 0, dir 1, alive 1, period reloaded to TICK_DIV, step_pulse 1.
REQ-020 hit in DEAD SHALL be ignored.
REQ-021 speed_up SHALL set period to max(period>>1, MIN_DIV), effective the following cycle; a same-cycle tick uses the old period; prescaler count is not cleared, but if count >= new period it SHALL be reset to 0.
REQ-022 enable=0 SHALL freeze prescaler, state, x_pos, dir and respawn counter; hit and speed_up SHALL still be accepted.
REQ-023 step_pulse SHALL be 0 in all cycles other than those in REQ-012; never asserted in DEAD except on respawn.

Reset
REQ-024 On reset_n=0, asynchronously: state MOVE, x_pos 0, dir 1, alive 1, step_pulse 0, prescaler 0, period TICK_DIV, respawn counter 0.
REQ-025 Reset mid-DEAD or mid-count SHALL discard all progress; first tick after release occurs TICK_DIV enabled cycles later.

Structure
REQ-026 Shared package alien_pkg SHALL hold the state enum (MOVE, DEAD), POS_W=3, POS_MAX=7.
REQ-027 Prescaler plus period register SHALL be one sub-module, alien_step_timer (inputs enable, clear, speed_up; output tick).
REQ-028 All outputs SHALL come directly from flops; no combinational path from inputs to outputs.

Verification (TICK_DIV=4, MIN_DIV=1, RESPAWN_STEPS=2)
REQ-029 Reset release, enable=1 for 32 cycles -> x_pos 1,2,...,7,6 at cycles 4,8,...,32; dir 0 from cycle 32; step_pulse exactly 8 times.
REQ-030 Run to x=0 moving left -> next tick x_pos 1, dir 1.
REQ-031 hit at x=5 coincident with tick -> x_pos stays 5, alive 0; after 8 enabled cycles x_pos 0, dir 1, alive 1, step_pulse once; second hit while DEAD no effect.
REQ-032 speed_up x3 -> step interval 2, then 1, then 1 (floor); after respawn interval 4 again.
REQ-033 enable low 10 cycles mid-count at count 2 -> no output change; tick 2 enabled cycles after enable returns.
REQ-034 reset_n asserted mid-DEAD -> outputs immediately x_pos 0, dir 1, alive 1, step_pulse 0.
